// File: rtl/present80_pkg.sv
// Shared constants, S-boxes and state type for the PRESENT-80 decryption key schedule.
// Includes rotation helpers used by the combinational key-update step.
package present80_pkg;

    localparam int KEY_W  = 80;
    localparam int RK_W   = 64;
    localparam int ROUNDS = 31;
    localparam int CTR_W  = 6;
    localparam int RND_W  = 5;

    localparam logic [CTR_W-1:0] CTR_FIRST    = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_FWD_LAST = CTR_W'(ROUNDS);
    localparam logic [CTR_W-1:0] CTR_TOP      = CTR_W'(ROUNDS + 1);

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } ks_state_e;

    function automatic logic [KEY_W-1:0] rotl61(input logic [KEY_W-1:0] k);
        return {k[18:0], k[79:19]};
    endfunction

    function automatic logic [KEY_W-1:0] rotr61(input logic [KEY_W-1:0] k);
        return {k[60:0], k[79:61]};
    endfunction

endpackage

// File: rtl/present80_dec_key_sched_if.sv
// Handshake/data bundle between the key scheduler and its controller/consumer.
// master drives start/key_in/rk_ready; slave (the scheduler) drives the rest.
interface present80_dec_key_sched_if;
    import present80_pkg::*;

    logic              start;
    logic [KEY_W-1:0]  key_in;
    logic              busy;
    logic              rk_valid;
    logic              rk_ready;
    logic [RK_W-1:0]   rk_out;
    logic [CTR_W-1:0]  rk_idx;
    logic              done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_idx, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_idx, done
    );

endinterface

// File: rtl/present80_ks_step.sv
// One PRESENT-80 key-register update, forward (i_inv=0) or its exact inverse (i_inv=1).
// Purely combinational; the inverse undoes the forward update with the same round number.
module present80_ks_step
    import present80_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [RND_W-1:0] i_round,
    input  logic             i_inv,
    output logic [KEY_W-1:0] o_key
);

    logic [KEY_W-1:0] w_fwd;
    logic [KEY_W-1:0] w_inv_pre;

    always_comb begin
        w_fwd          = rotl61(i_key);
        w_fwd[79:76]   = SBOX[w_fwd[79:76]];
        w_fwd[19:15]   = w_fwd[19:15] ^ i_round;

        // Inverse order: undo counter XOR, then S-box, then the rotation.
        w_inv_pre        = i_key;
        w_inv_pre[19:15] = w_inv_pre[19:15] ^ i_round;
        w_inv_pre[79:76] = INV_SBOX[w_inv_pre[79:76]];

        o_key = i_inv ? rotr61(w_inv_pre) : w_fwd;
    end

endmodule

// File: rtl/present80_dec_key_sched.sv
// PRESENT-80 decryption key schedule: walks forward to K32, then emits K32..K1 on valid/ready.
// Optional macro PRESENT_KS_CACHE_EN caches the last master/final key pair to skip the forward walk.
//
// state | meaning
// IDLE  | waiting for start
// FWD   | forward updates i=1..31, one per cycle
// EMIT  | presenting K[ctr]; inverse update on each handshake
// FIN   | last key taken; done pulses on the following cycle
module present80_dec_key_sched
    import present80_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    present80_dec_key_sched_if.slave  io_ks
);

    ks_state_e         r_state;
    ks_state_e         w_state_nxt;
    logic [KEY_W-1:0]  r_key;
    logic [KEY_W-1:0]  w_key_nxt;
    logic [KEY_W-1:0]  w_step_key;
    logic [CTR_W-1:0]  r_ctr;
    logic [CTR_W-1:0]  w_ctr_nxt;
    logic [RND_W-1:0]  w_step_round;
    logic              w_step_inv;
    logic              r_done;

`ifdef PRESENT_KS_CACHE_EN
    logic [KEY_W-1:0]  r_mkey;
    logic [KEY_W-1:0]  r_cache_mkey;
    logic [KEY_W-1:0]  r_cache_fkey;
    logic              r_cache_vld;
    logic              w_cache_hit;
    logic              w_cache_load;

    assign w_cache_hit = r_cache_vld && (io_ks.key_in == r_cache_mkey);
`endif

    present80_ks_step u_step (
        .i_key   (r_key),
        .i_round (w_step_round),
        .i_inv   (w_step_inv),
        .o_key   (w_step_key)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_key_nxt    = r_key;
        w_ctr_nxt    = r_ctr;
        w_step_round = r_ctr[RND_W-1:0];
        w_step_inv   = 1'b0;
`ifdef PRESENT_KS_CACHE_EN
        w_cache_load = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (io_ks.start) begin
`ifdef PRESENT_KS_CACHE_EN
                    if (w_cache_hit) begin
                        w_key_nxt   = r_cache_fkey;
                        w_ctr_nxt   = CTR_TOP;
                        w_state_nxt = ST_EMIT;
                    end else
`endif
                    begin
                        w_key_nxt   = io_ks.key_in;
                        w_ctr_nxt   = CTR_FIRST;
                        w_state_nxt = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                w_key_nxt = w_step_key;
                w_ctr_nxt = r_ctr + CTR_W'(1);
                if (r_ctr == CTR_FWD_LAST) begin
                    w_state_nxt = ST_EMIT;
`ifdef PRESENT_KS_CACHE_EN
                    w_cache_load = 1'b1;
`endif
                end
            end
            ST_EMIT: begin
                // ctr=32 gives round 31 through the 5-bit wrap, which is what K32->K31 needs.
                w_step_round = r_ctr[RND_W-1:0] - RND_W'(1);
                w_step_inv   = 1'b1;
                if (io_ks.rk_ready) begin
                    if (r_ctr > CTR_FIRST) begin
                        w_key_nxt = w_step_key;
                        w_ctr_nxt = r_ctr - CTR_W'(1);
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_ctr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_ctr   <= w_ctr_nxt;
            r_done  <= (r_state == ST_FIN);
        end
    end

`ifdef PRESENT_KS_CACHE_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mkey       <= '0;
            r_cache_mkey <= '0;
            r_cache_fkey <= '0;
            r_cache_vld  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && io_ks.start && !w_cache_hit) begin
                r_mkey <= io_ks.key_in;
            end
            if (w_cache_load) begin
                r_cache_mkey <= r_mkey;
                r_cache_fkey <= w_step_key;
                r_cache_vld  <= 1'b1;
            end
        end
    end
`endif

    assign io_ks.busy     = (r_state != ST_IDLE);
    assign io_ks.rk_valid = (r_state == ST_EMIT);
    assign io_ks.rk_out   = r_key[KEY_W-1:KEY_W-RK_W];
    assign io_ks.rk_idx   = r_ctr;
    assign io_ks.done     = r_done;

endmodule

// File: tb/tb_present80_dec_key_sched.sv
// Self-checking bench for present80_dec_key_sched: random keys against a forward-only software schedule.
// Build with +define+PRESENT_KS_CACHE_EN to expect cache hits.
module tb_present80_dec_key_sched;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [63:0] exp_rk [0:32];
    logic [63:0] obs_rk [0:32];

    localparam logic [3:0] TB_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

`ifdef PRESENT_KS_CACHE_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 31;
`endif

    present80_dec_key_sched_if kif ();

    present80_dec_key_sched dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .io_ks     (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward schedule in plain arithmetic: round key i is the register after i-1 updates.
    task automatic compute_model(input logic [79:0] mk);
        logic [79:0] k;
        k = mk;
        for (int i = 1; i <= 32; i++) begin
            exp_rk[i] = k[79:16];
            k = (k << 61) | (k >> 19);
            k[79:76] = TB_SBOX[k[79:76]];
            k[19:15] = k[19:15] ^ i[4:0];
        end
    endtask

    function automatic logic [79:0] rand_key();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    task automatic run_seq(input string name, input logic [79:0] key, input bit bp,
                           input bit poke, input int exp_lat);
        int c;
        int idx;
        int guard;
        bit rdy;
        compute_model(key);
        kif.rk_ready = 1'b1;
        kif.start    = 1'b1;
        kif.key_in   = key;
        @(posedge clk); #1;
        kif.start  = 1'b0;
        kif.key_in = ~key;
        c = 0;
        while (!kif.rk_valid && c < 100) begin
            if (poke && c == 10) begin
                kif.start  = 1'b1;
                kif.key_in = key ^ 80'h1;
            end else begin
                kif.start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        kif.start = 1'b0;
        total++;
        if (c !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, c, exp_lat);
        end
        if (!kif.rk_valid) return;
        idx = 32;
        guard = 0;
        while (idx > 0 && guard < 400) begin
            total++;
            if (kif.rk_valid !== 1'b1 || kif.rk_idx !== 6'(idx) || kif.rk_out !== exp_rk[idx]) begin
                bad++;
                $display("FAIL %s key: valid=%0b idx=%0d out=%h want idx=%0d out=%h",
                         name, kif.rk_valid, kif.rk_idx, kif.rk_out, idx, exp_rk[idx]);
            end
            obs_rk[idx] = kif.rk_out;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            kif.rk_ready = rdy;
            if (poke && idx == 20) begin
                kif.start  = 1'b1;
                kif.key_in = key ^ 80'h2;
            end else begin
                kif.start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
            guard++;
            if (rdy) idx--;
        end
        kif.start    = 1'b0;
        kif.rk_ready = 1'b1;
        total++;
        if (idx != 0) begin
            bad++;
            $display("FAIL %s emit timeout: remaining %0d want 0", name, idx);
            return;
        end
        total++;
        if (kif.rk_valid !== 1'b0 || kif.done !== 1'b0 || kif.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s fin: valid=%0b done=%0b busy=%0b want 0 0 1",
                     name, kif.rk_valid, kif.done, kif.busy);
        end
        @(posedge clk); #1;
        c++;
        total++;
        if (kif.done !== 1'b1 || kif.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done: done=%0b busy=%0b want 1 0", name, kif.done, kif.busy);
        end
        if (!bp) begin
            total++;
            if (c !== exp_lat + 33) begin
                bad++;
                $display("FAIL %s done edge: got %0d want %0d", name, c, exp_lat + 33);
            end
        end
        @(posedge clk); #1;
        total++;
        if (kif.done !== 1'b0) begin
            bad++;
            $display("FAIL %s done width: done=%0b want 0", name, kif.done);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        kif.start    = 1'b0;
        kif.key_in   = '0;
        kif.rk_ready = 1'b1;
        #3;
        total++;
        if (kif.busy !== 1'b0 || kif.rk_valid !== 1'b0 || kif.rk_out !== 64'h0 ||
            kif.rk_idx !== 6'd0 || kif.done !== 1'b0) begin
            bad++;
            $display("FAIL reset values: busy=%0b valid=%0b out=%h idx=%0d done=%0b want all 0",
                     kif.busy, kif.rk_valid, kif.rk_out, kif.rk_idx, kif.done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        run_seq("zero_key", 80'h0, 1'b0, 1'b0, 31);
        total++;
        if (obs_rk[2] !== 64'hC000_0000_0000_0000) begin
            bad++;
            $display("FAIL zero_key idx2: got %h want c000000000000000", obs_rk[2]);
        end
        total++;
        if (obs_rk[1] !== 64'h0) begin
            bad++;
            $display("FAIL zero_key idx1: got %h want 0", obs_rk[1]);
        end
    endtask

    task automatic test_all_ones_bp();
        run_seq("ones_bp", {80{1'b1}}, 1'b1, 1'b0, 31);
        total++;
        if (obs_rk[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL ones_bp idx1: got %h want ffffffffffffffff", obs_rk[1]);
        end
    endtask

    task automatic test_start_busy();
        run_seq("start_busy", rand_key(), 1'b0, 1'b1, 31);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            run_seq("random_bp", rand_key(), 1'b1, 1'b0, 31);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        bit done_seen;
        kif.rk_ready = 1'b1;
        kif.start    = 1'b1;
        kif.key_in   = rand_key();
        @(posedge clk); #1;
        kif.start = 1'b0;
        g = 0;
        while (!(kif.rk_valid && kif.rk_idx == 6'd17) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        total++;
        if (g >= 200) begin
            bad++;
            $display("FAIL reset_mid reach idx17: waited %0d want <200", g);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (kif.busy !== 1'b0 || kif.rk_valid !== 1'b0 || kif.rk_out !== 64'h0 ||
            kif.rk_idx !== 6'd0 || kif.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid async: busy=%0b valid=%0b out=%h idx=%0d done=%0b want all 0",
                     kif.busy, kif.rk_valid, kif.rk_out, kif.rk_idx, kif.done);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (kif.done !== 1'b0 || kif.busy !== 1'b0) done_seen = 1'b1;
        end
        total++;
        if (done_seen) begin
            bad++;
            $display("FAIL reset_mid quiet: activity=1 want 0");
        end
        // Release reset in the same cycle start is raised.
        rst_n = 1'b1;
        run_seq("after_reset", rand_key(), 1'b0, 1'b0, 31);
    endtask

    task automatic test_cache();
        logic [79:0] ka;
        logic [79:0] kb;
        ka = rand_key();
        kb = ~ka;
        run_seq("cache_a_first", ka, 1'b0, 1'b0, 31);
        run_seq("cache_a_again", ka, 1'b0, 1'b0, HIT_LAT);
        run_seq("cache_miss_b", kb, 1'b1, 1'b0, 31);
        run_seq("cache_a_evicted", ka, 1'b0, 1'b0, 31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero_key();
        test_all_ones_bp();
        test_start_busy();
        test_random();
        test_reset_mid();
        test_cache();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
